flash_program_sequencer: RTL

- Sequences the QSPI memory controller to program a multi-page image into serial NOR flash.
- Optionally checks the JEDEC ID first.
- Erases each 64 KB sector on first entry, then issues WREN + PP for every 256 B page.
- Sits between the host-side page source (UART/FIFO loader) and the controller's trigger/cmd/data_send/busy/error/readout interface.

---
 rtl/flash_program_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/flash_program_sequencer.sv
// flash_program_sequencer: drives a QSPI controller through ID check, sector erase and page programming
module flash_program_sequencer #(
  parameter bit CHECK_ID = 1'b1,
  parameter logic [7:0] EXPECTED_ID = 8'h20,
  parameter int SECTOR_BITS = 16,
  parameter bit QUAD = 1'b0
) (
  input  logic CLK_100M,
  input  logic RESET_N,
  input  logic start,
  input  logic [23:0] base_addr,
  input  logic [15:0] num_pages,
  input  logic page_valid,
  input  logic [2047:0] page_data,
  output logic page_ready,
  output logic mc_trigger,
  output logic [7:0] mc_cmd,
  output logic mc_quad,
  output logic [2071:0] mc_data_send,
  input  logic mc_busy,
  input  logic mc_error,
  input  logic [7:0] mc_readout,
  output logic busy,
  output logic done,
  output logic [2:0] err_code,
  output logic [15:0] pages_done
);
  localparam logic [7:0] CMD_WREN = 8'h06, CMD_RDID = 8'h9F, CMD_SE = 8'hD8, CMD_PP = 8'h02;
  typedef enum logic [3:0] {IDLE, RDID, SECT, WREN_E, ERASE, GETP, WREN_P, PROG, CWAIT, NEXT, DONE, FAIL} state_t;
  state_t state_q, ret_q;
  logic [23:0] addr_q;
  logic [15:0] remain_q;
  logic [2047:0] page_q;
  logic first_q, cw_first_q;
  logic [2:0] fcode_q;
  logic issue;
  logic [7:0] issue_cmd;
  logic [2071:0] issue_data;
  always_comb begin
    issue = (state_q inside {RDID, WREN_E, ERASE, WREN_P, PROG}) && !mc_busy;
    issue_cmd = state_q == RDID ? CMD_RDID : state_q == ERASE ? CMD_SE : state_q == PROG ? CMD_PP : CMD_WREN;
    issue_data = state_q == PROG ? {addr_q, page_q} : state_q == ERASE ? {2048'b0, addr_q} : '0;
  end
  always_ff @(posedge CLK_100M or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      ret_q <= IDLE;
      addr_q <= '0;
      remain_q <= '0;
      page_q <= '0;
      first_q <= 1'b0;
      cw_first_q <= 1'b0;
      fcode_q <= '0;
      page_ready <= 1'b0;
      mc_trigger <= 1'b0;
      mc_cmd <= '0;
      mc_quad <= 1'b0;
      mc_data_send <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err_code <= '0;
      pages_done <= '0;
    end else begin
      mc_trigger <= 1'b0;
      page_ready <= 1'b0;
      done <= 1'b0;
      if (issue) begin
        mc_trigger <= 1'b1;
        mc_cmd <= issue_cmd;
        mc_quad <= QUAD;
        mc_data_send <= issue_data;
        ret_q <= state_q;
        cw_first_q <= 1'b1;
        state_q <= CWAIT;
      end else begin
        case (state_q)
          IDLE: if (start) begin
            addr_q <= {base_addr[23:8], 8'h00};
            remain_q <= num_pages;
            pages_done <= '0;
            err_code <= '0;
            busy <= 1'b1;
            first_q <= 1'b1;
            state_q <= num_pages == 16'd0 ? DONE : (CHECK_ID ? RDID : SECT);
          end
          SECT: begin
            first_q <= 1'b0;
            state_q <= (first_q || addr_q[SECTOR_BITS-1:0] == '0) ? WREN_E : GETP;
          end
          GETP: if (page_valid) begin
            page_ready <= 1'b1;
            page_q <= page_data;
            state_q <= WREN_P;
          end
          CWAIT: begin
            cw_first_q <= 1'b0;
            if (!cw_first_q && !mc_busy) begin
              fcode_q <= ret_q == RDID ? 3'd1 : ret_q == ERASE ? 3'd2 : 3'd3;
              state_q <= ret_q == RDID ? (mc_readout != EXPECTED_ID ? FAIL : SECT) :
                         ret_q == WREN_E ? ERASE :
                         ret_q == ERASE ? (mc_error ? FAIL : GETP) :
                         ret_q == WREN_P ? PROG : (mc_error ? FAIL : NEXT);
            end
          end
          NEXT: begin
            pages_done <= pages_done < remain_q + pages_done ? pages_done + 16'd1 : pages_done;
            remain_q <= remain_q - 16'd1;
            fcode_q <= 3'd4;
            if (remain_q != 16'd1 && addr_q != 24'hFFFF00) addr_q <= addr_q + 24'd256;
            state_q <= remain_q == 16'd1 ? DONE : addr_q == 24'hFFFF00 ? FAIL : SECT;
          end
          DONE: begin
            done <= 1'b1;
            busy <= 1'b0;
            state_q <= IDLE;
          end
          FAIL: begin
            err_code <= fcode_q;
            done <= 1'b1;
            busy <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= state_q;
        endcase
      end
    end
  end
endmodule
